// File: rtl/axi_rd_responder_if.sv
// AXI read address/data channel bundle between the bus master and the read responder.
interface axi_rd_responder_if #(
    parameter int LEN_W = 4
);
    logic [31:0]      araddr;
    logic [LEN_W-1:0] arlen;
    logic             arvalid;
    logic             arready;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rlast;
    logic             rvalid;
    logic             rready;

    modport master (
        output araddr, arlen, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_responder.sv
// AXI read responder: accepts one AR burst at a time and turns each beat into a
// word read of packet memory or the register file. The read data arrives one
// cycle later and is returned on R with backpressure. All outputs are registered.
//
// state | meaning
// IDLE  | arready high, waiting for an AR handshake
// ISSUE | read enable pulse for the current beat is on the outputs
// CAPT  | target data valid on its input; load the R channel registers
// RESP  | R beat presented, holding until rready
module axi_rd_responder #(
    parameter int LEN_W   = 4,
    parameter int SEL_BIT = 8,
    parameter int TOP_BIT = 8
) (
    input  logic                Clk,
    input  logic                Rst,
    axi_rd_responder_if.slave   axi,
    output logic [3:0]          rd_en_mem,
    output logic [5:0]          addr_b,
    input  logic [31:0]         mem_rdata,
    output logic                rd_en_reg,
    output logic [5:0]          addr_reg,
    input  logic [31:0]         reg_rdata
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    state_t           state, state_nxt;
    logic [31:0]      cur, cur_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic             tgt, tgt_nxt;
    logic [1:0]       err, err_nxt;
    logic             issue;

    logic             arready_q, arready_nxt;
    logic             rvalid_q, rvalid_nxt;
    logic             rlast_q, rlast_nxt;
    logic [31:0]      rdata_q, rdata_nxt;
    logic [1:0]       rresp_q, rresp_nxt;
    logic [3:0]       rd_en_mem_nxt;
    logic             rd_en_reg_nxt;
    logic [5:0]       addr_b_nxt, addr_reg_nxt;

    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rlast   = rlast_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;

    // Next state and next values of every registered output; enables are
    // computed from the next beat address so they appear during ISSUE.
    always_comb begin
        state_nxt     = state;
        cur_nxt       = cur;
        cnt_nxt       = cnt;
        tgt_nxt       = tgt;
        err_nxt       = err;
        issue         = 1'b0;
        arready_nxt   = 1'b0;
        rvalid_nxt    = rvalid_q;
        rlast_nxt     = rlast_q;
        rdata_nxt     = rdata_q;
        rresp_nxt     = rresp_q;
        rd_en_mem_nxt = 4'b0000;
        rd_en_reg_nxt = 1'b0;
        addr_b_nxt    = addr_b;
        addr_reg_nxt  = addr_reg;

        case (state)
            IDLE: begin
                arready_nxt = 1'b1;
                if (axi.arvalid && arready_q) begin
                    cur_nxt     = axi.araddr;
                    cnt_nxt     = axi.arlen;
                    tgt_nxt     = axi.araddr[SEL_BIT];
                    if ((axi.araddr >> (TOP_BIT + 1)) != 32'd0)
                        err_nxt = RESP_DECERR;
                    else if (axi.araddr[1:0] != 2'b00)
                        err_nxt = RESP_SLVERR;
                    else
                        err_nxt = RESP_OKAY;
                    arready_nxt = 1'b0;
                    issue       = 1'b1;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = CAPT;
            end
            CAPT: begin
                if (err != RESP_OKAY)
                    rdata_nxt = 32'd0;
                else
                    rdata_nxt = tgt ? reg_rdata : mem_rdata;
                rresp_nxt  = err;
                rlast_nxt  = (cnt == '0);
                rvalid_nxt = 1'b1;
                state_nxt  = RESP;
            end
            RESP: begin
                if (rvalid_q && axi.rready) begin
                    rvalid_nxt = 1'b0;
                    rlast_nxt  = 1'b0;
                    if (rlast_q) begin
                        arready_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        cnt_nxt = cnt - LEN_W'(1);
                        // Word address wraps inside the target window; higher bits stay put.
                        if (tgt)
                            cur_nxt = {cur[31:6], cur[5:2] + 4'd1, cur[1:0]};
                        else
                            cur_nxt = {cur[31:8], cur[7:2] + 6'd1, cur[1:0]};
                        issue     = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (issue && err_nxt == RESP_OKAY) begin
            if (tgt_nxt) begin
                rd_en_reg_nxt = 1'b1;
                addr_reg_nxt  = cur_nxt[5:0];
            end else begin
                rd_en_mem_nxt = 4'b1111;
                addr_b_nxt    = cur_nxt[7:2];
            end
        end
    end

    // State, burst context and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= IDLE;
            cur       <= '0;
            cnt       <= '0;
            tgt       <= 1'b0;
            err       <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rd_en_mem <= 4'b0000;
            rd_en_reg <= 1'b0;
            addr_b    <= '0;
            addr_reg  <= '0;
        end else begin
            state     <= state_nxt;
            cur       <= cur_nxt;
            cnt       <= cnt_nxt;
            tgt       <= tgt_nxt;
            err       <= err_nxt;
            arready_q <= arready_nxt;
            rvalid_q  <= rvalid_nxt;
            rlast_q   <= rlast_nxt;
            rdata_q   <= rdata_nxt;
            rresp_q   <= rresp_nxt;
            rd_en_mem <= rd_en_mem_nxt;
            rd_en_reg <= rd_en_reg_nxt;
            addr_b    <= addr_b_nxt;
            addr_reg  <= addr_reg_nxt;
        end
    end
endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder with a one-cycle-latency memory and register file model.
module tb_axi_rd_responder;
    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [3:0]  rd_en_mem;
    logic [5:0]  addr_b;
    logic [31:0] mem_rdata = '0;
    logic        rd_en_reg;
    logic [5:0]  addr_reg;
    logic [31:0] reg_rdata = '0;

    axi_rd_responder_if #(.LEN_W(4)) axi ();

    axi_rd_responder #(.LEN_W(4), .SEL_BIT(8), .TOP_BIT(8)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .axi       (axi.slave),
        .rd_en_mem (rd_en_mem),
        .addr_b    (addr_b),
        .mem_rdata (mem_rdata),
        .rd_en_reg (rd_en_reg),
        .addr_reg  (addr_reg),
        .reg_rdata (reg_rdata)
    );

    always #5 Clk = ~Clk;

    logic [31:0] mem  [64];
    logic [31:0] regs [16];

    // Target model: data valid one cycle after the enable.
    always @(posedge Clk) begin
        if (rd_en_mem == 4'b1111) mem_rdata <= mem[addr_b];
        if (rd_en_reg)            reg_rdata <= regs[addr_reg[5:2]];
    end

    int          n_mem_en, n_reg_en;
    logic [5:0]  q_addr_b[$];
    logic [5:0]  q_addr_reg[$];

    // Enable monitor.
    always @(negedge Clk) begin
        if (Rst) begin
            if (rd_en_mem != 4'b0000) begin
                n_mem_en++;
                q_addr_b.push_back(addr_b);
            end
            if (rd_en_reg) begin
                n_reg_en++;
                q_addr_reg.push_back(addr_reg);
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    logic [31:0] got_data[$];
    logic [1:0]  got_resp[$];
    logic        got_last[$];

    task automatic clear_log();
        n_mem_en = 0;
        n_reg_en = 0;
        q_addr_b.delete();
        q_addr_reg.delete();
        got_data.delete();
        got_resp.delete();
        got_last.delete();
    endtask

    // Leaves the caller at the negedge after the AR handshake edge.
    task automatic send_ar(input logic [31:0] addr, input logic [3:0] len);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (axi.arready) begin ok = 1; break; end
        end
        if (!ok) check_val("arready_timeout", 32'd0, 32'd1);
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arvalid = 1'b1;
        @(negedge Clk);
        axi.arvalid = 1'b0;
        axi.araddr  = 32'hFFFF_FFFF;
    endtask

    task automatic wait_rvalid(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (axi.rvalid) begin ok = 1; break; end
            @(negedge Clk);
        end
        if (!ok) check_val("rvalid_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [3:0] len);
        bit ok;
        clear_log();
        axi.rready = 1'b1;
        send_ar(addr, len);
        for (int b = 0; b <= int'(len); b++) begin
            wait_rvalid(ok);
            if (!ok) return;
            got_data.push_back(axi.rdata);
            got_resp.push_back(axi.rresp);
            got_last.push_back(axi.rlast);
            @(negedge Clk);
        end
        @(negedge Clk);
    endtask

    bit ok;
    logic [31:0] hold_data;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[4] = 32'hDEAD_BEEF;
        for (int i = 0; i < 16; i++) regs[i] = 32'hC000_0000 + i;
        axi.araddr  = '0;
        axi.arlen   = '0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        clear_log();

        // Reset state
        repeat (3) @(negedge Clk);
        check_val("rst_arready", {31'd0, axi.arready}, 32'd0);
        check_val("rst_rvalid",  {31'd0, axi.rvalid},  32'd0);
        check_val("rst_rdata",   axi.rdata,            32'd0);
        check_val("rst_rd_en",   {28'd0, rd_en_mem},   32'd0);
        Rst = 1'b1;
        @(negedge Clk);
        check_val("idle_arready", {31'd0, axi.arready}, 32'd1);

        // Single memory read, exact latency
        clear_log();
        axi.rready = 1'b1;
        send_ar(32'h0000_0010, 4'd0);
        check_val("t1_rd_en_mem", {28'd0, rd_en_mem}, 32'h0000_000F);
        check_val("t1_addr_b",    {26'd0, addr_b},    32'd4);
        check_val("t1_arready_lo", {31'd0, axi.arready}, 32'd0);
        @(negedge Clk);
        check_val("t1_rd_en_off", {28'd0, rd_en_mem}, 32'd0);
        check_val("t1_rvalid_early", {31'd0, axi.rvalid}, 32'd0);
        @(negedge Clk);
        check_val("t1_rvalid", {31'd0, axi.rvalid}, 32'd1);
        check_val("t1_rdata",  axi.rdata,           32'hDEAD_BEEF);
        check_val("t1_rresp",  {30'd0, axi.rresp},  32'd0);
        check_val("t1_rlast",  {31'd0, axi.rlast},  32'd1);
        @(negedge Clk);
        check_val("t1_rvalid_off", {31'd0, axi.rvalid}, 32'd0);
        check_val("t1_arready_back", {31'd0, axi.arready}, 32'd1);
        check_val("t1_mem_en_count", n_mem_en, 32'd1);

        // Register burst with address wrap at 60
        read_burst(32'h0000_0138, 4'd3);
        check_val("t2_reg_en_count", n_reg_en, 32'd4);
        check_val("t2_mem_en_count", n_mem_en, 32'd0);
        check_val("t2_beats", got_data.size(), 32'd4);
        if (q_addr_reg.size() == 4 && got_data.size() == 4) begin
            check_val("t2_addr0", {26'd0, q_addr_reg[0]}, 32'h38);
            check_val("t2_addr1", {26'd0, q_addr_reg[1]}, 32'h3C);
            check_val("t2_addr2", {26'd0, q_addr_reg[2]}, 32'h00);
            check_val("t2_addr3", {26'd0, q_addr_reg[3]}, 32'h04);
            check_val("t2_data0", got_data[0], 32'hC000_000E);
            check_val("t2_data1", got_data[1], 32'hC000_000F);
            check_val("t2_data2", got_data[2], 32'hC000_0000);
            check_val("t2_data3", got_data[3], 32'hC000_0001);
            check_val("t2_lasts", {28'd0, got_last[0], got_last[1], got_last[2], got_last[3]}, 32'b0001);
        end

        // Memory wrap 63 -> 0
        read_burst(32'h0000_00FC, 4'd1);
        check_val("t3_reg_en_count", n_reg_en, 32'd0);
        check_val("t3_mem_en_count", n_mem_en, 32'd2);
        if (q_addr_b.size() == 2 && got_data.size() == 2) begin
            check_val("t3_addr0", {26'd0, q_addr_b[0]}, 32'd63);
            check_val("t3_addr1", {26'd0, q_addr_b[1]}, 32'd0);
            check_val("t3_data0", got_data[0], 32'h1000_003F);
            check_val("t3_data1", got_data[1], 32'h1000_0000);
        end

        // Backpressure on beat 1
        clear_log();
        axi.rready = 1'b0;
        send_ar(32'h0000_0020, 4'd1);
        wait_rvalid(ok);
        hold_data = axi.rdata;
        check_val("t4_data0", hold_data, 32'h1000_0008);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check_val("t4_hold_rvalid", {31'd0, axi.rvalid}, 32'd1);
            check_val("t4_hold_rdata",  axi.rdata,           32'h1000_0008);
            check_val("t4_hold_rlast",  {31'd0, axi.rlast},  32'd0);
            check_val("t4_hold_rresp",  {30'd0, axi.rresp},  32'd0);
            check_val("t4_hold_en",     n_mem_en,            32'd1);
        end
        axi.rready = 1'b1;
        @(negedge Clk);
        wait_rvalid(ok);
        check_val("t4_data1", axi.rdata, 32'h1000_0009);
        check_val("t4_last1", {31'd0, axi.rlast}, 32'd1);
        check_val("t4_mem_en_count", n_mem_en, 32'd2);
        @(negedge Clk);

        // Unaligned: SLVERR, no enables
        read_burst(32'h0000_0012, 4'd1);
        check_val("t5_beats", got_data.size(), 32'd2);
        check_val("t5_enables", n_mem_en + n_reg_en, 32'd0);
        if (got_data.size() == 2) begin
            check_val("t5_resp0", {30'd0, got_resp[0]}, 32'd2);
            check_val("t5_resp1", {30'd0, got_resp[1]}, 32'd2);
            check_val("t5_data0", got_data[0], 32'd0);
            check_val("t5_lasts", {30'd0, got_last[0], got_last[1]}, 32'b01);
        end

        // Out of range: DECERR
        read_burst(32'h0000_0400, 4'd0);
        check_val("t6_beats", got_data.size(), 32'd1);
        check_val("t6_enables", n_mem_en + n_reg_en, 32'd0);
        if (got_data.size() == 1) begin
            check_val("t6_resp", {30'd0, got_resp[0]}, 32'd3);
            check_val("t6_last", {31'd0, got_last[0]}, 32'd1);
            check_val("t6_data", got_data[0], 32'd0);
        end

        // Reset during beat 3 of an 8-beat burst
        clear_log();
        axi.rready = 1'b1;
        send_ar(32'h0000_0000, 4'd7);
        for (int b = 0; b < 2; b++) begin
            wait_rvalid(ok);
            @(negedge Clk);
        end
        axi.rready = 1'b0;
        wait_rvalid(ok);
        check_val("t7_beat3_data", axi.rdata, 32'h1000_0002);
        Rst = 1'b0;
        @(negedge Clk);
        check_val("t7_rvalid",  {31'd0, axi.rvalid},  32'd0);
        check_val("t7_rlast",   {31'd0, axi.rlast},   32'd0);
        check_val("t7_arready", {31'd0, axi.arready}, 32'd0);
        check_val("t7_rdata",   axi.rdata,            32'd0);
        check_val("t7_addr_b",  {26'd0, addr_b},      32'd0);
        check_val("t7_rd_en",   {27'd0, rd_en_mem, rd_en_reg}, 32'd0);
        Rst = 1'b1;
        @(negedge Clk);
        check_val("t7_arready_after", {31'd0, axi.arready}, 32'd1);
        read_burst(32'h0000_0010, 4'd0);
        check_val("t7_new_beats", got_data.size(), 32'd1);
        if (got_data.size() == 1) begin
            check_val("t7_new_data", got_data[0], 32'hDEAD_BEEF);
            check_val("t7_new_resp", {30'd0, got_resp[0]}, 32'd0);
            check_val("t7_new_last", {31'd0, got_last[0]}, 32'd1);
        end
        check_val("t7_new_addr_count", q_addr_b.size(), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
